// File: rtl/axis_rr_scheduler.sv
// Four-input round-robin AXI-Stream scheduler; each grant carries up to BURST_LENGTH words.
// Optional AXIS_RR_SCHEDULER_TLAST_EN adds m_axis_tlast on the final word of every grant.
module axis_rr_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BURST_LENGTH     = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [4*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [3:0]                    s_axis_tvalid,
  output logic [3:0]                    s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [1:0]                    m_axis_tid,
  output logic                          m_axis_tvalid,
`ifdef AXIS_RR_SCHEDULER_TLAST_EN
  output logic                          m_axis_tlast,
`endif
  input  logic                          m_axis_tready
);

  localparam int          W        = AXIS_TDATA_WIDTH;
  localparam logic [15:0] CNT_LAST = 16'(BURST_LENGTH - 1);
  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_GRANT  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [1:0]   grant_q, grant_d;
  logic [1:0]   last_q, last_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   tid_q, tid_d;
  logic         valid_q, valid_d;

  logic         out_free, serving, accept, release_grant, burst_end, found;
  logic [1:0]   pick;
  logic [W-1:0] gdata;

  assign out_free      = ~valid_q | m_axis_tready;
  assign serving       = (state_q == S_GRANT) & out_free;
  assign accept        = serving & s_axis_tvalid[grant_q];
  assign release_grant = serving & ~s_axis_tvalid[grant_q];
  assign burst_end     = accept & (cnt_q == CNT_LAST);

  // Search starts one past the last grant; k == 4 wraps back to last_q itself.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!found && s_axis_tvalid[last_q + 2'(k)]) begin
        pick  = last_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant_q == 2'(i)) gdata = s_axis_tdata[i*W +: W];
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (serving) s_axis_tready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          grant_d = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (release_grant || burst_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AXIS_RR_SCHEDULER_TLAST_EN
  logic         tlast_q, tlast_d;
  logic         hold_valid_q, hold_valid_d, hold_last_q, hold_last_d;
  logic [W-1:0] hold_data_q, hold_data_d;
  logic [1:0]   hold_tid_q, hold_tid_d;
  logic         push;

  // Accepted words wait one slot in the hold register so the grant's end is known
  // before the word leaves; a final word is flushed as soon as the output frees.
  assign push = hold_valid_q & out_free & (accept | hold_last_q | release_grant);

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    hold_data_d  = hold_data_q;
    hold_tid_d   = hold_tid_q;
    data_d       = data_q;
    tid_d        = tid_q;
    tlast_d      = tlast_q;
    valid_d      = valid_q & ~m_axis_tready;
    if (push) begin
      data_d  = hold_data_q;
      tid_d   = hold_tid_q;
      tlast_d = hold_last_q | release_grant;
      valid_d = 1'b1;
    end
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = gdata;
      hold_tid_d   = grant_q;
      hold_last_d  = burst_end;
    end else if (push) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tlast_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_tid_q   <= '0;
    end else begin
      tlast_q      <= tlast_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      hold_data_q  <= hold_data_d;
      hold_tid_q   <= hold_tid_d;
    end
  end

  assign m_axis_tlast = tlast_q;
`else
  always_comb begin
    data_d  = data_q;
    tid_d   = tid_q;
    valid_d = valid_q & ~m_axis_tready;
    if (accept) begin
      data_d  = gdata;
      tid_d   = grant_q;
      valid_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      data_q  <= '0;
      tid_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tid_q   <= tid_d;
      valid_q <= valid_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tid    = tid_q;
  assign m_axis_tvalid = valid_q;

endmodule

// File: doc/axis_rr_scheduler.md
AXIS_RR_SCHEDULER -- requirements
Module: axis_rr_scheduler

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32, SHALL set the width of each stream data word.
REQ-002 Parameter BURST_LENGTH, default 16, range 1..65536, SHALL set the maximum words transferred per grant.
REQ-003 Port aclk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port aresetn, input, 1: reset, asynchronous assertion, active-low.
REQ-005 Port s_axis_tdata, input, 4*AXIS_TDATA_WIDTH: requester data, requester i at bits [i*W +: W].
REQ-006 Port s_axis_tvalid, input, 4: per-requester valid.
REQ-007 Port s_axis_tready, output, 4: per-requester ready.
REQ-008 Port m_axis_tdata, output, AXIS_TDATA_WIDTH: merged output data.
REQ-009 Port m_axis_tid, output, 2: index of the requester that sourced the current output word.
REQ-010 Port m_axis_tvalid, output, 1: output valid.
REQ-011 Port m_axis_tready, input, 1: output ready.
REQ-012 Port m_axis_tlast, output, 1: end-of-burst marker; present only under REQ-031.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-014 In IDLE with any s_axis_tvalid high, the block SHALL grant the first valid index searching from (last_grant+1) mod 4 upward with wrap, then enter GRANT next cycle.
REQ-015 In IDLE with no valid requester, the state, grant and pointer SHALL hold.
REQ-016 s_axis_tready[i] SHALL be high only in GRANT, for i equal to the grant, and when (~m_axis_tvalid | m_axis_tready); all other bits SHALL be 0.
REQ-017 On an accepted input word, the output register SHALL load tdata and tid on the same edge and set m_axis_tvalid.
REQ-018 m_axis_tvalid SHALL clear on an edge where m_axis_tready is high and no new word is loaded.
REQ-019 Output data, tid and tlast SHALL stay stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-020 Latency SHALL be: requester valid in IDLE at cycle 0, grant in cycle 1, acceptance at the end of cycle 1, m_axis_tvalid high in cycle 2.
REQ-021 A word counter, 16 bits wide, SHALL count words accepted in the current grant.
REQ-022 Acceptance of the BURST_LENGTH-th word SHALL return the FSM to IDLE and clear the counter.
REQ-023 In GRANT, a cycle with the granted s_axis_tvalid low SHALL return the FSM to IDLE (early release) with no transfer and the counter cleared.
REQ-024 last_grant SHALL update when GRANT is entered, so a requester that released early loses priority.
REQ-025 Every grant SHALL be followed by at least one IDLE cycle; sustained throughput is BURST_LENGTH/(BURST_LENGTH+1).
REQ-026 With BURST_LENGTH=1, each grant SHALL carry exactly one word, and all four requesters active SHALL rotate 0,1,2,3,0.
REQ-027 With m_axis_tready held low, GRANT SHALL persist with s_axis_tready low; the counter and the early-release check SHALL be evaluated only on cycles where s_axis_tready is high.

Reset
REQ-028 While aresetn is low: state IDLE, counter 0, last_grant 3 (first priority index 0), s_axis_tready 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tid 0, m_axis_tlast 0.
REQ-029 Reset asserted mid-burst SHALL discard the held output word; no partial state SHALL survive.
REQ-030 After deassertion, arbitration SHALL restart per REQ-014 from priority index 0.

Configuration
REQ-031 With macro AXIS_RR_SCHEDULER_TLAST_EN defined, m_axis_tlast SHALL be registered with the data and high for the word that ends a grant, whether by the count reaching BURST_LENGTH or by early release.
REQ-032 For early release, the block SHALL hold one word so that tlast can mark the final accepted word, and SHALL flush that word with tlast=1 when the release is detected.
REQ-033 Without AXIS_RR_SCHEDULER_TLAST_EN, there SHALL be no m_axis_tlast port and no holding word, and behaviour SHALL be per REQ-013..027.

Verification
REQ-034 With BURST_LENGTH=4, all 4 valid continuously and m_axis_tready=1, the bench SHALL check output tid sequence 0,0,0,0,1,1,1,1,2,...,3,0 with one idle cycle between bursts.
REQ-035 With only requester 2 valid and 3 words queued, the bench SHALL check a 3-word grant, early release, then requester 2 re-granted once it is valid again and no other requester is valid.
REQ-036 With m_axis_tready toggling 1,0,0,1, the bench SHALL check data stable during stalls, no loss or duplication, and counter advance only on acceptances.
REQ-037 Asserting aresetn low in the middle of a burst (word 2 of 4), the bench SHALL check all outputs 0 immediately; after release with requesters 1 and 3 valid, requester 1 SHALL be granted first.
REQ-038 With TLAST_EN and BURST_LENGTH=4, the bench SHALL check tlast=1 exactly on the 4th word; after an early release after 2 words, tlast=1 on word 2.
